// File: rtl/sd_pkg.sv
// Shared definitions for the SD card command sequencer: command indices,
// card/error encodings and the sequencer state type.
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD3  = 6'd3;
  localparam logic [5:0] CMD7  = 6'd7;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD16 = 6'd16;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [31:0] SD_BLOCK_BYTES = 32'd512;

  typedef enum logic [1:0] {
    CARD_UNKNOWN = 2'd0,
    CARD_SDV1    = 2'd1,
    CARD_SDV2_SC = 2'd2,
    CARD_SDV2_HC = 2'd3
  } card_type_t;

  typedef enum logic [3:0] {
    ERR_NONE         = 4'd0,
    ERR_CMD8         = 4'd1,
    ERR_ACMD41_LIMIT = 4'd2,
    ERR_ACMD41       = 4'd3,
    ERR_IDENT        = 4'd4
  } err_code_t;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_IDLE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/sd_init_seq.sv
// SD power-up / identification sequencer and single-block read command issuer.
// The held cmd_idx doubles as the "which step" register for the ISSUE/WAIT pair.
module sd_init_seq
  import sd_pkg::*;
#(
  parameter logic [15:0] SLOW_CLKDIV = 16'd124,
  parameter logic [15:0] FAST_CLKDIV = 16'd1,
  parameter logic [15:0] ACMD41_MAX  = 16'd2000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] clkdiv,
  output logic        cmd_start,
  output logic [15:0] cmd_precnt,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxe,
  input  logic [31:0] cmd_resparg,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_ack,
  output logic        rd_go,
  output logic        rd_err,
  output logic        init_done,
  output logic [1:0]  card_type,
  output logic [15:0] rca,
  output logic        error,
  output logic [3:0]  err_code
);

  state_t      state;
  card_type_t  ctype;
  err_code_t   ecode;
  logic [15:0] attempts;
  logic [15:0] attempts_inc;
  logic        resp_ok;
  logic        unused_resp_bits;

  assign resp_ok          = !cmd_timeout && !cmd_syntaxe;
  assign attempts_inc     = (attempts == 16'hFFFF) ? attempts : attempts + 16'd1;
  assign card_type        = ctype;
  assign err_code         = ecode;
  assign unused_resp_bits = ^cmd_resparg[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ISSUE;
      clkdiv     <= SLOW_CLKDIV;
      cmd_start  <= 1'b0;
      cmd_precnt <= 16'd64;
      cmd_idx    <= CMD0;
      cmd_arg    <= 32'h0;
      rd_ack     <= 1'b0;
      rd_go      <= 1'b0;
      rd_err     <= 1'b0;
      init_done  <= 1'b0;
      ctype      <= CARD_UNKNOWN;
      rca        <= 16'h0;
      error      <= 1'b0;
      ecode      <= ERR_NONE;
      attempts   <= 16'h0;
    end else begin
      cmd_start <= 1'b0;
      rd_ack    <= 1'b0;
      rd_go     <= 1'b0;
      rd_err    <= 1'b0;
      case (state)
        ST_ISSUE: begin
          if (!cmd_busy) begin
            cmd_start <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd_done) begin
            state <= ST_ISSUE;
            case (cmd_idx)
              CMD0: begin
                cmd_idx    <= CMD8;
                cmd_arg    <= 32'h0000_01AA;
                cmd_precnt <= 16'd2;
              end
              CMD8: begin
                if (cmd_timeout) begin
                  ctype   <= CARD_SDV1;
                  cmd_idx <= CMD55;
                  cmd_arg <= 32'h0;
                end else if (resp_ok && cmd_resparg[11:0] == 12'h1AA) begin
                  ctype   <= CARD_SDV2_SC;
                  cmd_idx <= CMD55;
                  cmd_arg <= 32'h0;
                end else begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_CMD8;
                end
              end
              CMD55: begin
                if (!resp_ok) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_ACMD41;
                end else begin
                  cmd_idx <= CMD41;
                  cmd_arg <= (ctype >= CARD_SDV2_SC) ? 32'hC010_0000 : 32'h0010_0000;
                end
              end
              // Syntax errors are ignored here: ACMD41 (R3) carries no CRC.
              CMD41: begin
                if (cmd_timeout) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_ACMD41;
                end else if (!cmd_resparg[31]) begin
                  attempts <= attempts_inc;
                  if (attempts_inc >= ACMD41_MAX) begin
                    state <= ST_ERROR;
                    error <= 1'b1;
                    ecode <= ERR_ACMD41_LIMIT;
                  end else begin
                    cmd_idx <= CMD55;
                    cmd_arg <= 32'h0;
                  end
                end else begin
                  if (cmd_resparg[30] && ctype == CARD_SDV2_SC) ctype <= CARD_SDV2_HC;
                  cmd_idx <= CMD2;
                  cmd_arg <= 32'h0;
                end
              end
              CMD2: begin
                if (cmd_timeout) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_IDENT;
                end else begin
                  cmd_idx <= CMD3;
                  cmd_arg <= 32'h0;
                end
              end
              CMD3: begin
                if (!resp_ok) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_IDENT;
                end else begin
                  rca     <= cmd_resparg[31:16];
                  cmd_idx <= CMD7;
                  cmd_arg <= {cmd_resparg[31:16], 16'h0};
                end
              end
              CMD7: begin
                if (!resp_ok) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_IDENT;
                end else if (ctype != CARD_SDV2_HC) begin
                  cmd_idx <= CMD16;
                  cmd_arg <= SD_BLOCK_BYTES;
                end else begin
                  clkdiv    <= FAST_CLKDIV;
                  init_done <= 1'b1;
                  state     <= ST_IDLE;
                end
              end
              CMD16: begin
                if (!resp_ok) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
                  ecode <= ERR_IDENT;
                end else begin
                  clkdiv    <= FAST_CLKDIV;
                  init_done <= 1'b1;
                  state     <= ST_IDLE;
                end
              end
              CMD17: begin
                state <= ST_IDLE;
                if (resp_ok) rd_go  <= 1'b1;
                else         rd_err <= 1'b1;
              end
              default: begin
                state <= ST_ERROR;
                error <= 1'b1;
                ecode <= ERR_IDENT;
              end
            endcase
          end
        end
        // High-capacity cards are block addressed; older cards take a byte address.
        ST_IDLE: begin
          if (rd_req) begin
            rd_ack  <= 1'b1;
            cmd_idx <= CMD17;
            cmd_arg <= (ctype == CARD_SDV2_HC) ? rd_sector : {rd_sector[22:0], 9'h0};
            state   <= ST_ISSUE;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Self-checking bench for sd_init_seq: a behavioural command-engine model answers
// each cmd_start, and expected commands are queued per scenario and popped on issue.
module tb_sd_init_seq;
  import sd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clkdiv;
  logic        cmd_start;
  logic [15:0] cmd_precnt;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_busy;
  logic        cmd_done;
  logic        cmd_timeout;
  logic        cmd_syntaxe;
  logic [31:0] cmd_resparg;
  logic        rd_req;
  logic [31:0] rd_sector;
  logic        rd_ack;
  logic        rd_go;
  logic        rd_err;
  logic        init_done;
  logic [1:0]  card_type;
  logic [15:0] rca;
  logic        error;
  logic [3:0]  err_code;

  always #5 clk = ~clk;

  sd_init_seq #(
    .SLOW_CLKDIV(16'd124),
    .FAST_CLKDIV(16'd1),
    .ACMD41_MAX (16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkdiv     (clkdiv),
    .cmd_start  (cmd_start),
    .cmd_precnt (cmd_precnt),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .cmd_busy   (cmd_busy),
    .cmd_done   (cmd_done),
    .cmd_timeout(cmd_timeout),
    .cmd_syntaxe(cmd_syntaxe),
    .cmd_resparg(cmd_resparg),
    .rd_req     (rd_req),
    .rd_sector  (rd_sector),
    .rd_ack     (rd_ack),
    .rd_go      (rd_go),
    .rd_err     (rd_err),
    .init_done  (init_done),
    .card_type  (card_type),
    .rca        (rca),
    .error      (error),
    .err_code   (err_code)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
  } exp_cmd_t;

  exp_cmd_t    expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cmd8Mode;
  int          acmdNotReady;
  int          acmdCalls;
  logic [31:0] acmdReady;
  logic [31:0] cmd3Resp;
  logic        rd17Timeout;
  int          ackCount = 0;
  int          ackBase;

  always @(posedge clk) if (rd_ack === 1'b1) ackCount <= ackCount + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic expectCmd(input logic [5:0] idx, input logic [31:0] arg);
    exp_cmd_t e;
    e.idx = idx;
    e.arg = arg;
    expQ.push_back(e);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_clkdiv",    32'(clkdiv),     32'd124);
    checkOutput("rst_precnt",    32'(cmd_precnt), 32'd64);
    checkOutput("rst_cmd_start", 32'(cmd_start),  32'd0);
    checkOutput("rst_cmd_idx",   32'(cmd_idx),    32'd0);
    checkOutput("rst_cmd_arg",   cmd_arg,         32'd0);
    checkOutput("rst_rd_pulses", {29'd0, rd_ack, rd_go, rd_err}, 32'd0);
    checkOutput("rst_init_done", 32'(init_done),  32'd0);
    checkOutput("rst_card_type", 32'(card_type),  32'd0);
    checkOutput("rst_rca",       32'(rca),        32'd0);
    checkOutput("rst_error",     32'(error),      32'd0);
    checkOutput("rst_err_code",  32'(err_code),   32'd0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    cmd_busy = 1'b0;
    cmd_done = 1'b0;
    cmd_timeout = 1'b0;
    cmd_syntaxe = 1'b0;
    @(negedge clk);
    checkResetValues();
    acmdCalls = 0;
    expQ.delete();
    rst = 1'b0;
  endtask

  task automatic driveResponse(input logic [5:0] idx);
    cmd_timeout = 1'b0;
    cmd_syntaxe = 1'b0;
    cmd_resparg = 32'h0000_0900;
    case (idx)
      6'd0: cmd_timeout = 1'b1;
      6'd8: begin
        if (cmd8Mode == 0) cmd_timeout = 1'b1;
        else cmd_resparg = (cmd8Mode == 1) ? 32'h0000_01AA : 32'h0000_0155;
      end
      6'd41: begin
        cmd_resparg = (acmdCalls < acmdNotReady) ? 32'h00FF_8000 : acmdReady;
        acmdCalls++;
      end
      6'd3:  cmd_resparg = cmd3Resp;
      6'd17: cmd_timeout = rd17Timeout;
      default: cmd_resparg = 32'h0000_0900;
    endcase
  endtask

  task automatic serveOne(output bit served);
    int n = 0;
    exp_cmd_t e;
    logic [5:0] idx;
    served = 1'b0;
    while (cmd_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (rd_ack === 1'b1) rd_req = 1'b0;
    end
    if (cmd_start !== 1'b1) begin
      checkOutput("cmd_start_timeout", 32'd0, 32'd1);
      return;
    end
    idx = cmd_idx;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_cmd", {26'd0, idx}, 32'hFFFF_FFFF);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("cmd_idx_%0d", e.idx), 32'(idx), 32'(e.idx));
      checkOutput($sformatf("cmd_arg_%0d", e.idx), cmd_arg, e.arg);
    end
    if (idx == 6'd0) checkOutput("precnt_cmd0", 32'(cmd_precnt), 32'd64);
    if (idx == 6'd8) checkOutput("precnt_cmd8", 32'(cmd_precnt), 32'd2);
    served = 1'b1;
    cmd_busy = 1'b1;
    @(negedge clk);
    checkOutput("cmd_start_width", 32'(cmd_start), 32'd0);
    repeat (2) @(negedge clk);
    driveResponse(idx);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_timeout = 1'b0;
    cmd_syntaxe = 1'b0;
    cmd_busy = 1'b0;
  endtask

  task automatic serveAll();
    bit ok;
    while (expQ.size() > 0) begin
      serveOne(ok);
      if (!ok) expQ.delete();
    end
  endtask

  task automatic checkNoStarts(input string tag);
    int starts = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_start === 1'b1) starts++;
    end
    checkOutput(tag, 32'(starts), 32'd0);
  endtask

  // Requests a read in IDLE and waits (bounded) for the one-cycle acknowledge.
  task automatic applyStimulus(input logic [31:0] sector);
    int n = 0;
    rd_sector = sector;
    rd_req = 1'b1;
    while (rd_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    @(negedge clk);
    checkOutput("rd_ack_width", 32'(rd_ack), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b1;
    cmd_busy = 1'b0;
    cmd_done = 1'b0;
    cmd_timeout = 1'b0;
    cmd_syntaxe = 1'b0;
    cmd_resparg = 32'h0;
    rd_req = 1'b0;
    rd_sector = 32'h0;
    rd17Timeout = 1'b0;

    // SDv1 card: CMD8 times out, first ACMD41 ready, CMD16 issued, then reads.
    cmd8Mode = 0; acmdNotReady = 0; acmdReady = 32'hC0FF_8000; cmd3Resp = 32'h1234_0000;
    resetDut();
    expectCmd(CMD0, 32'h0);
    expectCmd(CMD8, 32'h1AA);
    expectCmd(CMD55, 32'h0);
    expectCmd(CMD41, 32'h0010_0000);
    expectCmd(CMD2, 32'h0);
    expectCmd(CMD3, 32'h0);
    expectCmd(CMD7, 32'h1234_0000);
    expectCmd(CMD16, 32'd512);
    serveAll();
    @(negedge clk);
    checkOutput("v1_init_done", 32'(init_done), 32'd1);
    checkOutput("v1_clkdiv",    32'(clkdiv),    32'd1);
    checkOutput("v1_card_type", 32'(card_type), 32'd1);
    checkOutput("v1_rca",       32'(rca),       32'h1234);
    checkOutput("v1_error",     32'(error),     32'd0);

    applyStimulus(32'd3);
    rd17Timeout = 1'b0;
    expectCmd(CMD17, 32'h0000_0600);
    serveOne(ok);
    checkOutput("rd_go",        32'(rd_go),  32'd1);
    checkOutput("rd_err_quiet", 32'(rd_err), 32'd0);
    @(negedge clk);
    checkOutput("rd_go_width",  32'(rd_go),  32'd0);

    applyStimulus(32'h0001_0001);
    rd17Timeout = 1'b1;
    expectCmd(CMD17, 32'h0200_0200);
    serveOne(ok);
    checkOutput("rd_err",       32'(rd_err), 32'd1);
    checkOutput("rd_go_quiet",  32'(rd_go),  32'd0);
    @(negedge clk);
    checkOutput("rd_err_width", 32'(rd_err), 32'd0);
    checkOutput("rd_idle_init", 32'(init_done), 32'd1);
    rd17Timeout = 1'b0;

    // SDv2 HC card, two busy ACMD41 replies; a read request pending during init.
    cmd8Mode = 1; acmdNotReady = 2; acmdReady = 32'hC0FF_8000; cmd3Resp = 32'hAAAA_0520;
    resetDut();
    rd_sector = 32'h0000_0077;
    rd_req = 1'b1;
    ackBase = ackCount;
    expectCmd(CMD0, 32'h0);
    expectCmd(CMD8, 32'h1AA);
    for (int i = 0; i < 3; i++) begin
      expectCmd(CMD55, 32'h0);
      expectCmd(CMD41, 32'hC010_0000);
    end
    expectCmd(CMD2, 32'h0);
    expectCmd(CMD3, 32'h0);
    expectCmd(CMD7, 32'hAAAA_0000);
    serveAll();
    checkOutput("hc_rd_held_off", 32'(ackCount - ackBase), 32'd0);
    checkOutput("hc_card_type",   32'(card_type), 32'd3);
    checkOutput("hc_rca",         32'(rca),       32'hAAAA);
    checkOutput("hc_init_done",   32'(init_done), 32'd1);
    expectCmd(CMD17, 32'h0000_0077);
    serveOne(ok);
    checkOutput("hc_rd_go",     32'(rd_go), 32'd1);
    checkOutput("hc_rd_acked",  32'(ackCount - ackBase), 32'd1);

    // Bad CMD8 echo: terminal error 1.
    cmd8Mode = 2; acmdNotReady = 0;
    resetDut();
    expectCmd(CMD0, 32'h0);
    expectCmd(CMD8, 32'h1AA);
    serveAll();
    checkOutput("c8_error",     32'(error),     32'd1);
    checkOutput("c8_err_code",  32'(err_code),  32'd1);
    checkOutput("c8_init_done", 32'(init_done), 32'd0);
    checkNoStarts("c8_no_start");

    // ACMD41 never ready: exactly ACMD41_MAX attempts, then error 2.
    cmd8Mode = 0; acmdNotReady = 1000;
    resetDut();
    expectCmd(CMD0, 32'h0);
    expectCmd(CMD8, 32'h1AA);
    for (int i = 0; i < 4; i++) begin
      expectCmd(CMD55, 32'h0);
      expectCmd(CMD41, 32'h0010_0000);
    end
    serveAll();
    checkOutput("lim_error",    32'(error),    32'd1);
    checkOutput("lim_err_code", 32'(err_code), 32'd2);
    checkNoStarts("lim_no_start");

    // Reset while waiting on CMD55.
    cmd8Mode = 1; acmdNotReady = 0;
    resetDut();
    expectCmd(CMD0, 32'h0);
    expectCmd(CMD8, 32'h1AA);
    serveAll();
    n = 0;
    while (cmd_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_cmd55_start", {31'd0, cmd_start}, 32'd1);
    checkOutput("mid_cmd55_idx",   32'(cmd_idx),       32'd55);
    cmd_busy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    cmd_busy = 1'b0;
    expQ.delete();
    expectCmd(CMD0, 32'h0);
    serveOne(ok);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
